// File: rtl/oam_dma_if.sv
// CPU snoop inputs, bus read data and DMA-owned bus outputs for the OAM DMA engine.
// The engine sits on the slave side; the system/CPU glue sits on the master side.
interface oam_dma_if;
    logic        i_cpu_rw;
    logic [15:0] i_cpu_address;
    logic [7:0]  i_cpu_data;
    logic [7:0]  i_data;
    logic        o_active;
    logic        o_rw;
    logic [15:0] o_address;
    logic [7:0]  o_data;
    logic [2:0]  o_debug_state;

    modport slave (
        input  i_cpu_rw,
        input  i_cpu_address,
        input  i_cpu_data,
        input  i_data,
        output o_active,
        output o_rw,
        output o_address,
        output o_data,
        output o_debug_state
    );

    modport master (
        output i_cpu_rw,
        output i_cpu_address,
        output i_cpu_data,
        output i_data,
        input  o_active,
        input  o_rw,
        input  o_address,
        input  o_data,
        input  o_debug_state
    );
endinterface

// File: rtl/oam_dma.sv
// OAM DMA: snoops CPU writes to the trigger register, halts the CPU and copies one page to OAMDATA.
// Trigger-to-idle is 513 cycles (514 when an align cycle is needed); no backpressure, the bus is owned outright.
module oam_dma #(
    parameter logic [15:0] TRIGGER_ADDR    = 16'h4014,
    parameter logic [15:0] OAMDATA_ADDR    = 16'h2004,
    parameter int unsigned TRANSFER_LENGTH = 256
) (
    input  logic        i_clk,
    input  logic        i_reset,
    oam_dma_if.slave    bus
);

    localparam logic [7:0] LAST_IDX = 8'(TRANSFER_LENGTH - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  page;
    logic [7:0]  counter;
    logic [7:0]  data_latch;
    logic        parity;
    logic        trigger;
    logic        last_byte;

    // Only an IDLE engine listens; writes landing mid-transfer are dropped.
    assign trigger   = (state == IDLE) && !bus.i_cpu_rw && (bus.i_cpu_address == TRIGGER_ADDR);
    assign last_byte = (counter == LAST_IDX);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (trigger) state_nxt = HALT;
            // Reads must land on even cycles; insert ALIGN when HALT sits on an even one.
            HALT:    state_nxt = parity ? READ : ALIGN;
            ALIGN:   state_nxt = READ;
            READ:    state_nxt = WRITE;
            WRITE:   state_nxt = last_byte ? IDLE : READ;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            parity     <= 1'b0;
            page       <= 8'h00;
            counter    <= 8'h00;
            data_latch <= 8'h00;
        end else begin
            parity <= ~parity;
            if (trigger) begin
                page    <= bus.i_cpu_data;
                counter <= 8'h00;
            end
            if (state == READ) begin
                data_latch <= bus.i_data;
            end
            if ((state == WRITE) && !last_byte) begin
                counter <= counter + 8'h01;
            end
        end
    end

    // Outputs depend on registered state only, so the bus mux never sees a CPU-input glitch.
    always_comb begin
        bus.o_active      = 1'b0;
        bus.o_rw          = 1'b1;
        bus.o_address     = 16'h0000;
        bus.o_data        = 8'h00;
        bus.o_debug_state = state;
        unique case (state)
            IDLE: begin
                bus.o_active = 1'b0;
            end
            HALT, ALIGN: begin
                bus.o_active = 1'b1;
            end
            READ: begin
                bus.o_active  = 1'b1;
                bus.o_address = {page, counter};
            end
            WRITE: begin
                bus.o_active  = 1'b1;
                bus.o_rw      = 1'b0;
                bus.o_address = OAMDATA_ADDR;
                bus.o_data    = data_latch;
            end
            default: begin
                bus.o_active = 1'b0;
            end
        endcase
    end

endmodule
